// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA raster timing generator.
// Divides the system clock down to the pixel rate, runs the horizontal and
// vertical raster counters, exports DrawX/DrawY to the color mapper and
// registers the mapper's RGB together with HS/VS/BLANK_N so that every DAC
// signal changes on the same pixel boundary (one pixel of latency).
// Optional feature: define VGA_FRAME_CNT_EN to add a 16-bit frame_count port.

module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CLK_DIV   = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] Red_in,
  input  logic [7:0] Green_in,
  input  logic [7:0] Blue_in,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
`ifdef VGA_FRAME_CNT_EN
  output logic [15:0] frame_count,
`endif
  output logic       frame_start,
  output logic       line_start
);

  // Raster geometry; both totals must fit the 10-bit counters.
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // Divider width and its decode points (CLK_DIV is at least 2).
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  // Counter decode points, pre-sized to the counter width.
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FP + V_SYNC);

  // Pixel-rate divider and the registered pixel clock.
  logic [DIV_W-1:0] div_q, div_d;
  logic             vga_clk_q, vga_clk_d;

  // Raster position of the pixel currently presented to the color mapper.
  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;

  // Output stage: everything here describes the previous pixel.
  logic [7:0] red_q, red_d;
  logic [7:0] green_q, green_d;
  logic [7:0] blue_q, blue_d;
  logic       blank_n_q, blank_n_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;

  // Decoded conditions on the current pixel.
  logic pix_en;
  logic h_wrap;
  logic v_wrap;
  logic visible;
  logic hs_active;
  logic vs_active;

  assign pix_en    = (div_q == DIV_LAST);
  assign h_wrap    = (hc_q == H_LAST);
  assign v_wrap    = (vc_q == V_LAST);
  assign visible   = (hc_q < H_VIS_END) && (vc_q < V_VIS_END);
  assign hs_active = (hc_q >= HS_START) && (hc_q < HS_END);
  assign vs_active = (vc_q >= VS_START) && (vc_q < VS_END);

  // Divider wraps on pix_en; VGA_CLK is high for the second half of each pixel
  // so its falling edge coincides with the output-stage update.
  always_comb begin
    div_d     = pix_en ? '0 : (div_q + DIV_ONE);
    vga_clk_d = (div_d >= DIV_HALF);
  end

  // Divider and pixel-clock registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      div_q     <= '0;
      vga_clk_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      vga_clk_q <= vga_clk_d;
    end
  end

  // Horizontal counter steps every pixel; vertical counter steps on line wrap.
  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (pix_en) begin
      if (h_wrap) begin
        hc_d = '0;
        vc_d = v_wrap ? '0 : (vc_q + 10'd1);
      end else begin
        hc_d = hc_q + 10'd1;
      end
    end
  end

  // Raster counter registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  // Output stage captures the current pixel's colour and syncs in one shot so
  // RGB, blanking and syncs all carry the same pixel on the DAC bus.
  always_comb begin
    red_d     = red_q;
    green_d   = green_q;
    blue_d    = blue_q;
    blank_n_d = blank_n_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    if (pix_en) begin
      red_d     = visible ? Red_in   : 8'h00;
      green_d   = visible ? Green_in : 8'h00;
      blue_d    = visible ? Blue_in  : 8'h00;
      blank_n_d = visible;
      hs_d      = ~hs_active;
      vs_d      = ~vs_active;
    end
  end

  // Output-stage registers; syncs idle high, video idles blanked and black.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      red_q     <= 8'h00;
      green_q   <= 8'h00;
      blue_q    <= 8'h00;
      blank_n_q <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
    end else begin
      red_q     <= red_d;
      green_q   <= green_d;
      blue_q    <= blue_d;
      blank_n_q <= blank_n_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
    end
  end

  // Strobes mark the clock whose edge moves the raster to a new line/frame.
  // pix_en is low throughout reset, so both are low there as well.
  assign line_start  = pix_en && h_wrap;
  assign frame_start = line_start && v_wrap;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Free-running frame counter for game logic; wraps naturally at 16 bits.
  always_comb begin
    frame_cnt_d = frame_start ? (frame_cnt_q + 16'd1) : frame_cnt_q;
  end

  // Frame counter register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_cnt_q <= 16'h0000;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_count = frame_cnt_q;
`endif

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign VGA_CLK     = vga_clk_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = red_q;
  assign VGA_G       = green_q;
  assign VGA_B       = blue_q;

endmodule
